// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR sequencer slice.
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, PRESENT} lfsr_seq_state_t;

  localparam int LFSR_N_DEF       = 26;
  localparam int LFSR_SEED_W_DEF  = 4;
  localparam int LFSR_WORDS_W_DEF = 8;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [63:0] seed_fix(input logic [63:0] seed);
    return (seed == 64'd0) ? 64'd1 : seed;
  endfunction

endpackage

// File: rtl/lfsr_shift_counter.sv
// Counts generate cycles within one output word; terminal count at N-1.
module lfsr_shift_counter #(
  parameter int N = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lfsr_sequencer.sv
// Drives load/gen of an external N-bit LFSR and streams one snapshot per N shifts.
// Optional all-zero lockup abort enabled by defining ZERO_LOCK_DET_EN.
module lfsr_sequencer
  import lfsr_pkg::*;
#(
  parameter int N       = LFSR_N_DEF,
  parameter int SEED_W  = LFSR_SEED_W_DEF,
  parameter int WORDS_W = LFSR_WORDS_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SEED_W-1:0]  req_seed,
  input  logic [WORDS_W-1:0] req_words,
  output logic               lfsr_load,
  output logic [N-1:0]       lfsr_seed,
  output logic               lfsr_gen,
  input  logic [N-1:0]       lfsr_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data,
  output logic               out_last,
  output logic               busy,
  output logic               err_zero
);

  lfsr_seq_state_t    state_q, state_d;
  logic [N-1:0]       seed_q, seed_d;
  logic [N-1:0]       data_q, data_d;
  logic [WORDS_W-1:0] words_q, words_d;
  logic               cap_q, cap_d;
  logic               rdy_q;
  logic               tc, req_hs, out_hs, zero_hit;
  logic [63:0]        seed_ext;
  logic               seed_unused;

  assign seed_ext    = seed_fix(64'(req_seed));
  assign seed_unused = ^seed_ext[63:N];

  // rdy_q keeps req_ready low until the first edge after reset release.
  assign req_ready = rdy_q && (state_q == IDLE);
  assign lfsr_load = (state_q == LOAD);
  assign lfsr_seed = lfsr_load ? seed_q : '0;
  assign lfsr_gen  = (state_q == RUN);
  assign out_valid = (state_q == PRESENT);
  assign out_data  = !out_valid ? '0 : (cap_q ? data_q : lfsr_q);
  assign out_last  = out_valid && (words_q == WORDS_W'(1));
  assign busy      = (state_q != IDLE);
  assign req_hs    = req_valid && req_ready;
  assign out_hs    = out_valid && out_ready;

`ifdef ZERO_LOCK_DET_EN
  assign zero_hit = (state_q == RUN) && (lfsr_q == '0);
`else
  assign zero_hit = 1'b0;
`endif
  assign err_zero = zero_hit;

  lfsr_shift_counter #(.N(N)) u_shift_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (lfsr_load | out_hs),
    .en_i  (lfsr_gen),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    words_d = words_q;
    data_d  = data_q;
    cap_d   = cap_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs && (req_words != '0)) begin
          seed_d  = seed_ext[N-1:0];
          words_d = req_words;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (zero_hit) begin
          state_d = IDLE;
        end else if (tc) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Datapath is stalled here, so the first PRESENT cycle's q is the snapshot.
        if (!cap_q) begin
          data_d = lfsr_q;
          cap_d  = 1'b1;
        end
        if (out_hs) begin
          words_d = words_q - WORDS_W'(1);
          cap_d   = 1'b0;
          state_d = (words_q == WORDS_W'(1)) ? IDLE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      seed_q  <= '0;
      words_q <= '0;
      data_q  <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      seed_q  <= seed_d;
      words_q <= words_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
    end
  end

endmodule
